// File: rtl/vector_cache_pkg.sv
// Purpose: shared payload types for the vector cache request and data paths.
// Latency: none (types and helpers only).
// Backpressure: none (types and helpers only).
//
// Contents:
//   us_txnid_t    - transaction id carried with every request/data beat
//   us_req_pld_t  - upstream request payload (txnid, address, opcode)
//   us_data_pld_t - upstream data payload (txnid, data, last)
//   master_id_of  - source index folded into a master_id field
package vector_cache_pkg;

  localparam int MASTER_ID_W = 4;
  localparam int TAG_W       = 8;
  localparam int ADDR_W      = 32;
  localparam int OPC_W       = 4;
  localparam int DATA_W      = 64;

  typedef struct packed {
    logic [MASTER_ID_W-1:0] master_id;
    logic [TAG_W-1:0]       tag;
  } us_txnid_t;

  typedef struct packed {
    us_txnid_t          txnid;
    logic [ADDR_W-1:0]  addr;
    logic [OPC_W-1:0]   opcode;
  } us_req_pld_t;

  typedef struct packed {
    us_txnid_t          txnid;
    logic [DATA_W-1:0]  data;
    logic               last;
  } us_data_pld_t;

  // Source index kept to $clog2(n) bits, then placed in the master_id field.
  function automatic logic [MASTER_ID_W-1:0] master_id_of(input int unsigned idx,
                                                          input int unsigned n);
    int unsigned mask;
    mask = (n > 1) ? ((32'd1 << $clog2(n)) - 32'd1) : 32'd0;
    return MASTER_ID_W'(idx & mask);
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Purpose: round-robin multi-grant ranker; grants up to i_cnt requesters starting at i_ptr.
// Latency: purely combinational.
// Backpressure: o_avail marks every master that would be granted if it requested.
//
// Ports:
//   i_req      - request vector, one bit per master
//   i_ptr      - round-robin start index
//   i_cnt      - number of grants available this cycle
//   o_avail    - master would be granted if it requested (independent of its own i_req)
//   o_gnt      - grant vector (i_req & o_avail)
//   o_rank     - per master: number of requesters ahead of it in round-robin order
//   o_last_idx - index of the last master granted in round-robin order
//   o_any      - at least one grant this cycle
module rr_multi_grant #(
  parameter  int N  = 16,
  parameter  int CW = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         i_req,
  input  logic [PW-1:0]        i_ptr,
  input  logic [CW-1:0]        i_cnt,
  output logic [N-1:0]         o_avail,
  output logic [N-1:0]         o_gnt,
  output logic [N-1:0][CW-1:0] o_rank,
  output logic [PW-1:0]        o_last_idx,
  output logic                 o_any
);

  logic [CW-1:0] w_seen;
  logic [PW-1:0] w_idx;

  // Walk the masters in round-robin order from i_ptr. A master is available
  // when fewer than i_cnt requesters precede it; its own request does not
  // enter its count, so availability never depends on its own valid.
  always_comb begin
    o_avail    = '0;
    o_gnt      = '0;
    o_rank     = '0;
    o_last_idx = i_ptr;
    o_any      = 1'b0;
    w_seen     = '0;
    w_idx      = '0;
    for (int i = 0; i < N; i++) begin
      w_idx         = PW'((int'(i_ptr) + i) % N);
      o_rank[w_idx] = w_seen;
      if (w_seen < i_cnt) begin
        o_avail[w_idx] = 1'b1;
        if (i_req[w_idx]) begin
          o_gnt[w_idx] = 1'b1;
          o_last_idx   = w_idx;
          o_any        = 1'b1;
        end
      end
      if (i_req[w_idx]) begin
        w_seen = w_seen + 1'b1;
      end
    end
  end

endmodule

// File: rtl/us_req_master_arb.sv
// Purpose: arbitrates N upstream master request ports onto M registered downstream lanes.
// Latency: 1 cycle from accept (in_vld & in_rdy) to out_vld on the chosen lane.
// Backpressure: a lane holds while out_vld & !out_rdy; in_rdy only offers as many grants as free lanes.
//
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   in_vld/in_rdy     - per-master request handshake
//   in_pld            - per-master request payload
//   out_vld/out_rdy   - per-lane downstream handshake
//   out_pld           - per-lane registered payload, master_id replaced with the source index
module us_req_master_arb
  import vector_cache_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_vld,
  output logic [N-1:0]        in_rdy,
  input  us_req_pld_t [N-1:0] in_pld,
  output logic [M-1:0]        out_vld,
  input  logic [M-1:0]        out_rdy,
  output us_req_pld_t [M-1:0] out_pld
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(((N > M) ? N : M) + 1);

  logic [M-1:0]          r_vld;
  us_req_pld_t [M-1:0]   r_pld;
  logic [PW-1:0]         r_ptr;

  logic [M-1:0]          w_free;
  logic [CW-1:0]         w_nfree;
  logic [M-1:0][CW-1:0]  w_lane_rank;
  logic [N-1:0]          w_avail;
  logic [N-1:0]          w_gnt;
  logic [N-1:0][CW-1:0]  w_rank;
  logic [PW-1:0]         w_last;
  logic                  w_any;
  logic [M-1:0]          w_load;
  us_req_pld_t [M-1:0]   w_load_pld;
  logic [PW-1:0]         w_ptr_nxt;

  // A lane is free when empty or draining this cycle. Each free lane gets an
  // ordinal among free lanes (ascending index) so the i-th grant lands in the
  // i-th free lane.
  always_comb begin
    w_free      = ~r_vld | out_rdy;
    w_nfree     = '0;
    w_lane_rank = '0;
    for (int k = 0; k < M; k++) begin
      w_lane_rank[k] = w_nfree;
      if (w_free[k]) begin
        w_nfree = w_nfree + 1'b1;
      end
    end
  end

  rr_multi_grant #(
    .N  (N),
    .CW (CW)
  ) u_rr_multi_grant (
    .i_req      (in_vld),
    .i_ptr      (r_ptr),
    .i_cnt      (w_nfree),
    .o_avail    (w_avail),
    .o_gnt      (w_gnt),
    .o_rank     (w_rank),
    .o_last_idx (w_last),
    .o_any      (w_any)
  );

  // A granted master's rank equals the ordinal of its destination lane; ranks
  // of granted masters are distinct, so at most one master matches a lane.
  always_comb begin
    w_load     = '0;
    w_load_pld = '0;
    for (int k = 0; k < M; k++) begin
      for (int j = 0; j < N; j++) begin
        if (w_free[k] && w_gnt[j] && (w_rank[j] == w_lane_rank[k])) begin
          w_load[k]                     = 1'b1;
          w_load_pld[k]                 = in_pld[j];
          w_load_pld[k].txnid.master_id = master_id_of(j, N);
        end
      end
    end
  end

  assign w_ptr_nxt = (w_last == PW'(N - 1)) ? '0 : w_last + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_pld <= '0;
      r_ptr <= '0;
    end else begin
      for (int k = 0; k < M; k++) begin
        if (w_load[k]) begin
          // Covers drain-and-reload in one cycle: no bubble.
          r_vld[k] <= 1'b1;
          r_pld[k] <= w_load_pld[k];
        end else if (out_rdy[k]) begin
          // Payload deliberately left as-is when the lane empties.
          r_vld[k] <= 1'b0;
        end
      end
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // Reset gates acceptance so nothing is handshaken while state is cleared.
  assign in_rdy  = w_avail & {N{rst_n}};
  assign out_vld = r_vld;
  assign out_pld = r_pld;

endmodule

// File: tb/tb_us_req_master_arb.sv
module tb_us_req_master_arb;
  import vector_cache_pkg::*;

  localparam int N = 16;
  localparam int M = 8;
  localparam logic [N-1:0] ONE = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        in_vld;
  logic [N-1:0]        in_rdy;
  us_req_pld_t [N-1:0] in_pld;
  logic [M-1:0]        out_vld;
  logic [M-1:0]        out_rdy;
  us_req_pld_t [M-1:0] out_pld;

  us_req_master_arb #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_pld  (in_pld),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_pld (out_pld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (lane contents, round-robin pointer) ----
  logic [M-1:0] m_vld;
  us_req_pld_t  m_pld [M];
  int           m_ptr;
  us_req_pld_t  sb_q [N][$];
  bit           strict_order = 1'b0;
  logic [N-1:0] acc_seen = '0;
  int           seq [N];

  logic [N-1:0] e_rdy, e_gnt;
  int           e_nfree, e_j, e_lane, e_last;
  bit           e_any;
  int           e_fq [$];
  int           sb_mid, sb_hit;
  bit           sb_ok;
  us_req_pld_t  sb_p;

  // Requesters picked walking round-robin from the pointer, up to nfree of them.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] vld, input int nfree);
    logic [N-1:0] g;
    int taken;
    g = '0;
    taken = 0;
    for (int s = 0; s < N; s++) begin
      if (vld[(m_ptr + s) % N] && taken < nfree) begin
        g[(m_ptr + s) % N] = 1'b1;
        taken++;
      end
    end
    return g;
  endfunction

  // Ready means: the master would be granted if it were requesting.
  function automatic bit would_grant(input int j, input int nfree);
    logic [N-1:0] g;
    g = rr_pick(in_vld | (ONE << j), nfree);
    return g[j];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      chk("rst_out_pld_zero", 64'(out_pld == '0), 64'd1);
      m_vld = '0;
      for (int k = 0; k < M; k++) m_pld[k] = '0;
      m_ptr = 0;
      for (int j = 0; j < N; j++) sb_q[j].delete();
      acc_seen = '0;
    end else begin
      e_nfree = 0;
      e_fq.delete();
      for (int k = 0; k < M; k++) begin
        if (!m_vld[k] || out_rdy[k]) begin
          e_nfree++;
          e_fq.push_back(k);
        end
      end
      for (int j = 0; j < N; j++) e_rdy[j] = would_grant(j, e_nfree);

      chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
      chk("out_vld", 64'(out_vld), 64'(m_vld));
      for (int k = 0; k < M; k++) chk($sformatf("lane%0d_pld", k), 64'(out_pld[k]), 64'(m_pld[k]));

      // Scoreboard: drained lanes must match a pending request of their master.
      for (int k = 0; k < M; k++) begin
        if (out_vld[k] && out_rdy[k]) begin
          sb_mid = int'(out_pld[k].txnid.master_id);
          sb_hit = -1;
          for (int i = 0; i < sb_q[sb_mid].size(); i++)
            if (sb_hit < 0 && sb_q[sb_mid][i] == out_pld[k]) sb_hit = i;
          sb_ok = (sb_hit == 0) || (!strict_order && sb_hit > 0);
          chk("sb_drain", 64'(sb_ok), 64'd1);
          if (sb_hit >= 0) sb_q[sb_mid].delete(sb_hit);
        end
      end
      for (int j = 0; j < N; j++) begin
        if (in_vld[j] && in_rdy[j]) begin
          sb_p = in_pld[j];
          sb_p.txnid.master_id = MASTER_ID_W'(j);
          sb_q[j].push_back(sb_p);
        end
      end
      acc_seen = in_vld & in_rdy;

      // Advance the model to the state after the coming edge.
      e_gnt = rr_pick(in_vld, e_nfree);
      m_vld = m_vld & ~out_rdy;
      e_any = 1'b0;
      e_last = 0;
      for (int s = 0; s < N; s++) begin
        e_j = (m_ptr + s) % N;
        if (e_gnt[e_j]) begin
          e_lane = e_fq.pop_front();
          m_vld[e_lane] = 1'b1;
          m_pld[e_lane] = in_pld[e_j];
          m_pld[e_lane].txnid.master_id = MASTER_ID_W'(e_j);
          e_any = 1'b1;
          e_last = e_j;
        end
      end
      if (e_any) m_ptr = (e_last + 1) % N;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  function automatic us_req_pld_t mk_pld(input int j, input int s);
    us_req_pld_t p;
    p.txnid.master_id = MASTER_ID_W'($urandom);
    p.txnid.tag       = 8'($urandom);
    p.addr            = (32'(j) << 24) | 32'(s);
    p.opcode          = 4'($urandom);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_plds();
    for (int j = 0; j < N; j++) begin
      seq[j]++;
      in_pld[j] = mk_pld(j, seq[j]);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_vld  = '0;
    out_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] lane_mids();
    logic [31:0] r;
    for (int k = 0; k < M; k++) r[4*k +: 4] = out_pld[k].txnid.master_id;
    return r;
  endfunction

  task automatic rand_phase(input int ncyc, input bit common);
    strict_order = common;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int j = 0; j < N; j++) begin
        if (!in_vld[j] || acc_seen[j]) begin
          in_vld[j] = ($urandom_range(0, 99) < 60);
          seq[j]++;
          in_pld[j] = mk_pld(j, seq[j]);
        end
      end
      if (common) out_rdy = {M{($urandom_range(0, 99) < 50)}};
      else        out_rdy = M'($urandom);
    end
  endtask

  task automatic drain();
    tick();
    in_vld  = '0;
    out_rdy = '1;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired before completion");
    $fatal(1);
  end

  int tot;

  initial begin
    rst_n   = 1'b0;
    in_vld  = '0;
    out_rdy = '0;
    in_pld  = '0;
    for (int j = 0; j < N; j++) seq[j] = 0;

    // Free run, all masters valid, all lanes ready.
    do_reset();
    new_plds();
    in_vld  = '1;
    out_rdy = '1;
    @(negedge clk);
    chk("r030_rdy_c1", 64'(in_rdy), 64'h00FF);
    tick();
    chk("r030_vld_c1", 64'(out_vld), 64'hFF);
    chk("r030_mid_c1", 64'(lane_mids()), 64'h76543210);
    new_plds();
    @(negedge clk);
    chk("r030_rdy_c2", 64'(in_rdy), 64'hFF00);
    tick();
    chk("r030_mid_c2", 64'(lane_mids()), 64'hFEDCBA98);

    // Backpressure: only lane 3 free, masters 5 and 9, pointer at 6.
    do_reset();
    new_plds();
    in_vld = 16'h0300;
    tick();
    new_plds();
    in_vld = 16'h003F;
    tick();
    chk("r031_setup_mid", 64'(lane_mids()), 64'h54321098);
    out_rdy = 8'h08;
    in_vld  = 16'h0220;
    @(negedge clk);
    chk("r031_rdy", 64'(in_rdy), 64'h03C0);
    tick();
    chk("r031_mid", 64'(lane_mids()), 64'h54329098);
    new_plds();
    out_rdy = '1;
    in_vld  = '1;
    @(negedge clk);
    chk("r031_rdy_ptr10", 64'(in_rdy), 64'hFC03);
    tick();
    chk("r031_lane0_mid", 64'(out_pld[0].txnid.master_id), 64'hA);

    // Wrap from pointer 14 with 2 free lanes, then stall with all lanes full.
    do_reset();
    new_plds();
    in_vld = 16'h3F00;
    tick();
    new_plds();
    in_vld = 16'h8005;
    @(negedge clk);
    chk("r033_gnt", 64'(in_rdy & in_vld), 64'h8001);
    tick();
    chk("r033_mid", 64'(lane_mids()), 64'h0FDCBA98);
    in_vld = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("r032_rdy", 64'(in_rdy), 64'h0);
      chk("r032_vld", 64'(out_vld), 64'hFF);
      chk("r032_mid", 64'(lane_mids()), 64'h0FDCBA98);
      tick();
    end
    out_rdy = '1;
    @(negedge clk);
    chk("r033_rdy_ptr1", 64'(in_rdy), 64'h01FE);
    tick();
    chk("r033_lane0_mid", 64'(out_pld[0].txnid.master_id), 64'h1);

    // Reset with all lanes loaded.
    chk("r034_pre_vld", 64'(out_vld), 64'hFF);
    rst_n = 1'b0;
    #1;
    chk("r034_vld", 64'(out_vld), 64'h0);
    chk("r034_rdy", 64'(in_rdy), 64'h0);
    chk("r034_pld", 64'(out_pld == '0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    new_plds();
    in_vld  = '1;
    out_rdy = '1;
    @(negedge clk);
    chk("r034_rdy_rel", 64'(in_rdy), 64'h00FF);
    tick();
    chk("r034_mid", 64'(lane_mids()), 64'h76543210);

    // Random traffic: independent lane backpressure, then uniform backpressure
    // where per-master order is checked strictly.
    rand_phase(600, 1'b0);
    drain();
    rand_phase(600, 1'b1);
    drain();
    @(negedge clk);
    #1;
    tot = 0;
    for (int j = 0; j < N; j++) tot += sb_q[j].size();
    chk("sb_empty", 64'(tot), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
